// File: rtl/fpu_ss_fpr_wb_arbiter.sv
// FP register file write-port arbiter: FPU results vs buffered load responses.
// Loads win by default; a bounded starvation counter forces an FPU grant.
module fpu_ss_fpr_wb_arbiter #(
  parameter int FLEN           = 32,
  parameter int LOAD_BUF_DEPTH = 2,
  parameter int MAX_FPU_WAIT   = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            fpu_valid_i,
  output logic            fpu_ready_o,
  input  logic [4:0]      fpu_addr_i,
  input  logic [FLEN-1:0] fpu_data_i,
  input  logic            ld_valid_i,
  input  logic [4:0]      ld_addr_i,
  input  logic [FLEN-1:0] ld_data_i,
  output logic            ld_buf_full_o,
  output logic            ld_buf_empty_o,
  output logic            ld_overflow_o,
  output logic            fpr_we_o,
  output logic [4:0]      fpr_waddr_o,
  output logic [FLEN-1:0] fpr_wdata_o,
  output logic            wb_src_o
);

  localparam int PW = (LOAD_BUF_DEPTH > 1) ? $clog2(LOAD_BUF_DEPTH) : 1;
  localparam int CW = $clog2(LOAD_BUF_DEPTH + 1);
  localparam int WW = (MAX_FPU_WAIT > 0) ? $clog2(MAX_FPU_WAIT + 1) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(LOAD_BUF_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(LOAD_BUF_DEPTH);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_FPU_WAIT);

  logic [4:0]      buf_addr_q [LOAD_BUF_DEPTH];
  logic [FLEN-1:0] buf_data_q [LOAD_BUF_DEPTH];
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic            ovf_q, ovf_d;
  logic            at_max, force_fpu, grant_ld, grant_fpu, push;

  assign ld_buf_empty_o = (count_q == '0);
  assign ld_buf_full_o  = (count_q == DEPTH_C);
  assign ld_overflow_o  = ovf_q;

  assign at_max      = (wait_q == WAIT_MAX);
  assign force_fpu   = fpu_valid_i & at_max;
  assign fpu_ready_o = ld_buf_empty_o | at_max;
  assign grant_ld    = ~ld_buf_empty_o & ~force_fpu;
  assign grant_fpu   = fpu_valid_i & fpu_ready_o;
  // A pop in the same cycle frees the slot the push lands in.
  assign push        = ld_valid_i & (~ld_buf_full_o | grant_ld);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CW'(push) - CW'(grant_ld);
    ovf_d   = ovf_q | (ld_valid_i & ~push);
    wait_d  = wait_q;
    if (grant_ld) head_d = (head_q == LAST_PTR) ? '0 : head_q + 1'b1;
    if (push)     tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + 1'b1;
    if (!fpu_valid_i || grant_fpu) wait_d = '0;
    else if (!at_max)              wait_d = wait_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      buf_addr_q[tail_q] <= ld_addr_i;
      buf_data_q[tail_q] <= ld_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      wait_q      <= '0;
      ovf_q       <= 1'b0;
      fpr_we_o    <= 1'b0;
      fpr_waddr_o <= '0;
      fpr_wdata_o <= '0;
      wb_src_o    <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      wait_q   <= wait_d;
      ovf_q    <= ovf_d;
      fpr_we_o <= grant_ld | grant_fpu;
      if (grant_ld) begin
        fpr_waddr_o <= buf_addr_q[head_q];
        fpr_wdata_o <= buf_data_q[head_q];
        wb_src_o    <= 1'b1;
      end else if (grant_fpu) begin
        fpr_waddr_o <= fpu_addr_i;
        fpr_wdata_o <= fpu_data_i;
        wb_src_o    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fpu_ss_fpr_wb_arbiter.sv
// Randomized bench: two arbiter configurations driven by shared stimulus,
// each compared every cycle against a queue-based behavioural model.
module tb_fpu_ss_fpr_wb_arbiter;

  localparam int FLEN = 32;
  localparam int NCYC = 3000;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic            rst_i, fpu_valid_i, ld_valid_i;
  logic [4:0]      fpu_addr_i, ld_addr_i;
  logic [FLEN-1:0] fpu_data_i, ld_data_i;

  logic [1:0]      rdy, full, empty, ovf, we, src;
  logic [4:0]      waddr [2];
  logic [FLEN-1:0] wdata [2];

  fpu_ss_fpr_wb_arbiter #(.FLEN(FLEN), .LOAD_BUF_DEPTH(2), .MAX_FPU_WAIT(4)) u_dut_a (
    .clk_i(clk_i), .rst_i(rst_i),
    .fpu_valid_i(fpu_valid_i), .fpu_ready_o(rdy[0]), .fpu_addr_i(fpu_addr_i), .fpu_data_i(fpu_data_i),
    .ld_valid_i(ld_valid_i), .ld_addr_i(ld_addr_i), .ld_data_i(ld_data_i),
    .ld_buf_full_o(full[0]), .ld_buf_empty_o(empty[0]), .ld_overflow_o(ovf[0]),
    .fpr_we_o(we[0]), .fpr_waddr_o(waddr[0]), .fpr_wdata_o(wdata[0]), .wb_src_o(src[0])
  );

  fpu_ss_fpr_wb_arbiter #(.FLEN(FLEN), .LOAD_BUF_DEPTH(3), .MAX_FPU_WAIT(0)) u_dut_b (
    .clk_i(clk_i), .rst_i(rst_i),
    .fpu_valid_i(fpu_valid_i), .fpu_ready_o(rdy[1]), .fpu_addr_i(fpu_addr_i), .fpu_data_i(fpu_data_i),
    .ld_valid_i(ld_valid_i), .ld_addr_i(ld_addr_i), .ld_data_i(ld_data_i),
    .ld_buf_full_o(full[1]), .ld_buf_empty_o(empty[1]), .ld_overflow_o(ovf[1]),
    .fpr_we_o(we[1]), .fpr_waddr_o(waddr[1]), .fpr_wdata_o(wdata[1]), .wb_src_o(src[1])
  );

  typedef struct {
    logic [36:0]     ent [8];
    int              cnt;
    int              wait_cyc;
    bit              ovf;
    bit              we;
    logic [4:0]      addr;
    logic [FLEN-1:0] data;
    bit              src;
  } model_t;

  model_t m [2];
  int     depth [2] = '{2, 3};
  int     maxw  [2] = '{4, 0};
  int     n_chk = 0;
  int     n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_dut(input int i);
    bit exp_rdy;
    exp_rdy = (m[i].cnt == 0) || (m[i].wait_cyc == maxw[i]);
    chk($sformatf("ready[%0d]", i), 64'(rdy[i]), 64'(exp_rdy));
    chk($sformatf("empty[%0d]", i), 64'(empty[i]), 64'(m[i].cnt == 0));
    chk($sformatf("full[%0d]", i), 64'(full[i]), 64'(m[i].cnt == depth[i]));
    chk($sformatf("ovf[%0d]", i), 64'(ovf[i]), 64'(m[i].ovf));
    chk($sformatf("we[%0d]", i), 64'(we[i]), 64'(m[i].we));
    chk($sformatf("waddr[%0d]", i), 64'(waddr[i]), 64'(m[i].addr));
    chk($sformatf("wdata[%0d]", i), 64'(wdata[i]), 64'(m[i].data));
    chk($sformatf("src[%0d]", i), 64'(src[i]), 64'(m[i].src));
  endtask

  // Advance model i across one rising edge using the currently driven inputs.
  task automatic step(input int i);
    bit at_max, ready, gl, gf;
    if (rst_i) begin
      m[i].cnt = 0; m[i].wait_cyc = 0; m[i].ovf = 0;
      m[i].we = 0; m[i].addr = '0; m[i].data = '0; m[i].src = 0;
      return;
    end
    at_max = (m[i].wait_cyc == maxw[i]);
    ready  = (m[i].cnt == 0) || at_max;
    gl     = (m[i].cnt != 0) && !(fpu_valid_i && at_max);
    gf     = fpu_valid_i && ready;
    m[i].we = gl || gf;
    if (gl) begin
      m[i].addr = m[i].ent[0][36:32];
      m[i].data = m[i].ent[0][31:0];
      m[i].src  = 1;
      for (int k = 0; k < 7; k++) m[i].ent[k] = m[i].ent[k+1];
      m[i].cnt--;
    end else if (gf) begin
      m[i].addr = fpu_addr_i;
      m[i].data = fpu_data_i;
      m[i].src  = 0;
    end
    if (!fpu_valid_i || gf) m[i].wait_cyc = 0;
    else if (m[i].wait_cyc < maxw[i]) m[i].wait_cyc++;
    if (ld_valid_i) begin
      if (m[i].cnt < depth[i]) begin
        m[i].ent[m[i].cnt] = {ld_addr_i, ld_data_i};
        m[i].cnt++;
      end else begin
        m[i].ovf = 1;
      end
    end
  endtask

  initial begin
    int pf, pl;
    rst_i = 1'b1; fpu_valid_i = 0; ld_valid_i = 0;
    fpu_addr_i = '0; ld_addr_i = '0; fpu_data_i = '0; ld_data_i = '0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk_i);
      if (cyc < 1000)      begin pf = 50; pl = 40; end
      else if (cyc < 2000) begin pf = 90; pl = 90; end
      else                 begin pf = 30; pl = 70; end
      rst_i       = (cyc < 2) || ($urandom_range(0, 99) == 0);
      fpu_valid_i = ($urandom_range(0, 99) < pf);
      ld_valid_i  = ($urandom_range(0, 99) < pl);
      fpu_addr_i  = 5'($urandom_range(0, 31));
      ld_addr_i   = 5'($urandom_range(0, 31));
      fpu_data_i  = $urandom;
      ld_data_i   = $urandom;
      #1;
      if (cyc > 0) begin
        check_dut(0);
        check_dut(1);
      end
      step(0);
      step(1);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fpu_ss_fpr_wb_arbiter.md
Name: fpu_ss_fpr_wb_arbiter

Overview:
- Arbitrates the single FP register file write port between two sources: FPU result stream and core memory load responses (loads/FLW).
- Load responses cannot be back-pressured (cmem response ready tied high), so they are buffered in a small FIFO.
- FPU results are back-pressured via ready; a starvation counter bounds FPU wait.
- Sits between FPnew output / cmem response channel and the FPR file, beside the FPU subsystem controller, which uses the buffer status flags to throttle load offload.

Parameters:
FLEN, 32, FP register/data width.
LOAD_BUF_DEPTH, 2, load-response FIFO entries (>=1, need not be power of 2).
MAX_FPU_WAIT, 4, cycles FPU may be stalled by buffered loads before forced grant; 0 = FPU strict priority.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
fpu_valid_i  in  1  FPU result valid (FP rd only)
fpu_ready_o  out  1  FPU result accepted
fpu_addr_i  in  5  FPU result destination FPR
fpu_data_i  in  FLEN  FPU result data
ld_valid_i  in  1  load response valid (no ready; always accepted unless overflow)
ld_addr_i  in  5  load destination FPR
ld_data_i  in  FLEN  load data
ld_buf_full_o  out  1  FIFO count == LOAD_BUF_DEPTH
ld_buf_empty_o  out  1  FIFO count == 0
ld_overflow_o  out  1  sticky: a load was dropped
fpr_we_o  out  1  FPR write enable (registered)
fpr_waddr_o  out  5  FPR write address (registered)
fpr_wdata_o  out  FLEN  FPR write data (registered)
wb_src_o  out  1  source of current write: 0 FPU, 1 load (registered)

Behaviour:
- Reset (sync, rst_i high at posedge): FIFO count/pointers 0, wait_cnt 0, fpr_we_o 0, fpr_waddr_o 0, fpr_wdata_o 0, wb_src_o 0, ld_overflow_o 0; ld_buf_empty_o 1, ld_buf_full_o 0 (LOAD_BUF_DEPTH>=1). Buffered loads discarded; reset overrides any same-cycle push/pop/grant.
- Load push: ld_valid_i=1 writes {addr,data} at tail every cycle unless FIFO full and no pop that cycle. Full with same-cycle pop: push accepted, count unchanged. Full without pop: entry dropped, ld_overflow_o set, remains 1 until reset.
- Newly arriving load is not eligible for grant in its arrival cycle (no bypass); earliest grant is next cycle.
- Arbitration (combinational, per cycle):
  - force = fpu_valid_i & (wait_cnt == MAX_FPU_WAIT).
  - fpu_ready_o = ld_buf_empty_o | (wait_cnt == MAX_FPU_WAIT); fpu_ready_o must not depend on fpu_valid_i.
  - grant_ld = ~ld_buf_empty_o & ~force; pops head.
  - grant_fpu = fpu_valid_i & fpu_ready_o.
  - At most one grant per cycle; grant_ld and grant_fpu mutually exclusive by construction.
- wait_cnt:
  - Next = 0 if ~fpu_valid_i or grant_fpu.
  - Else min(wait_cnt+1, MAX_FPU_WAIT).
  - Width $clog2(MAX_FPU_WAIT+1), min 1.
- Write port:
  - Cycle after a grant: fpr_we_o=1, waddr/wdata/wb_src from granted source.
  - No grant: fpr_we_o=0, waddr/wdata/wb_src hold last values.
  - Latency exactly 1 cycle from handshake/pop; throughput one write per cycle.
- Ordering:
  - FIFO preserves load order; FPU order preserved by handshake.
  - No cross-source same-address ordering guarantee; the controller scoreboard prevents such overlap.
- Flags reflect registered count (current cycle), not next state.

Test Plan:
- Lone FPU: fpu_valid_i=1 addr 3 data 0x3F800000, FIFO empty -> fpu_ready_o=1 same cycle; next cycle fpr_we_o=1, waddr 3, wdata 0x3F800000, wb_src 0; following cycle we=0.
- Load priority: ld addr 5 data 0x40000000 at c0; fpu addr 6 valid from c1.
  - c1: load popped, fpu_ready_o=0.
  - c2: write addr5 src1; fpu_ready_o=1.
  - c3: write addr6 src0.
- Starvation, MAX_FPU_WAIT=4: ld_valid_i every cycle, fpu_valid_i held from c1.
  - fpu_ready_o=0 for c1..c4, =1 at c5; FPU written c6.
  - At c5 no pop, so count 1->2 and ld_buf_full_o=1 at c6.
- Overflow, MAX_FPU_WAIT=0, DEPTH=2: fpu_valid_i held high, ld_valid_i c0..c2.
  - After c1: full=1.
  - c2 load dropped; ld_overflow_o=1 from c3, stays 1 until rst_i.
- Full with pop, DEPTH=2: FIFO full, fpu_valid_i=0, ld_valid_i=1 -> pop+push same cycle, count stays 2, ld_overflow_o stays 0, writes continue in order.
- Reset mid-op: 2 loads buffered, rst_i=1 one cycle -> next cycle fpr_we_o=0, empty=1, overflow=0; no further writes for discarded entries.
